// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle over 32 CALC cycles, signs applied to magnitudes at completion.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        is_div, is_signed, neg_res;
    logic [31:0] mag_a, mag_b, in_mag_a, in_mag_b;
    logic [32:0] mul_sum, div_top, div_diff;
    logic [63:0] mul_next, div_next, step, prod;
    logic [31:0] quot, rem;

    assign is_div    = op_q[1];
    assign is_signed = op_q[0];
    assign neg_res   = is_signed & (a_q[31] ^ b_q[31]);

    assign mag_a    = (is_signed && a_q[31]) ? -a_q : a_q;
    assign mag_b    = (is_signed && b_q[31]) ? -b_q : b_q;
    assign in_mag_a = (op[0] && a[31]) ? -a : a;
    assign in_mag_b = (op[0] && b[31]) ? -b : b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? mag_a : 32'd0)};
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step.
    assign div_top  = acc_q[63:31];
    assign div_diff = div_top - {1'b0, mag_b};
    assign div_next = (div_top >= {1'b0, mag_b}) ? {div_diff[31:0], acc_q[30:0], 1'b1}
                                                 : {div_top[31:0],  acc_q[30:0], 1'b0};

    assign step = is_div ? div_next : mul_next;
    assign prod = neg_res ? -step : step;
    assign quot = neg_res ? -step[31:0] : step[31:0];
    assign rem  = (is_signed && a_q[31]) ? -step[63:32] : step[63:32];

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CALC;
                    cnt_d   = 5'd0;
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    acc_d   = {32'd0, (op[1] ? in_mag_a : in_mag_b)};
                end
            end
            S_CALC: begin
                acc_d = step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                    if (is_div && b_q == 32'd0) begin
                        hi_d = a_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else if (is_div) begin
                        hi_d = rem;
                        lo_d = quot;
                    end else begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            acc_q   <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == S_CALC);
    assign done = (state_q == S_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
